// File: rtl/dx_hazard_ctrl.sv
// D->X flow controller: load-use and FP-unit hazards, jump flush bubbles,
// FP register pending-write scoreboard and a saturating stall counter.
module dx_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FP_LAT    = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs_a,
  input  logic [REG_AW-1:0] d_rt_a,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic              d_is_fp,
  input  logic [REG_AW-1:0] d_fs_a,
  input  logic [REG_AW-1:0] d_ft_a,
  input  logic [REG_AW-1:0] d_fd_a,
  input  logic              x_is_load,
  input  logic [REG_AW-1:0] x_rd_a,
  input  logic              x_jmp_taken,
  input  logic              m_stall,
  input  logic              fp_wb_valid,
  input  logic [REG_AW-1:0] fp_wb_a,
  output logic              fd_stall,
  output logic              dx_stall,
  output logic              dx_bubble,
  output logic              fp_issue,
  output logic              fp_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              dbg_state
);

  localparam int NREG = 1 << REG_AW;
  localparam int FC_W = $clog2(FP_LAT + 1);
  localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t            r_state;
  logic [FL_W-1:0]   r_flush_cnt;
  logic [FC_W-1:0]   r_fp_cnt;
  logic [NREG-1:0]   r_pending;
  logic [CNT_W-1:0]  r_stall_cnt;

  state_t            w_next_state;
  logic [FL_W-1:0]   w_next_flush;
  logic [NREG-1:0]   w_next_pending;
  logic              w_fp_busy;
  logic              w_load_use;
  logic              w_fp_haz;
  logic              w_hazard;
  logic              w_fd_stall;
  logic              w_dx_stall;
  logic              w_dx_bubble;
  logic              w_fp_issue;

  assign w_fp_busy  = (r_fp_cnt != '0);
  assign w_load_use = x_is_load && (x_rd_a != '0) &&
                      ((d_uses_rs && (d_rs_a == x_rd_a)) ||
                       (d_uses_rt && (d_rt_a == x_rd_a)));
  assign w_fp_haz   = d_is_fp && (w_fp_busy || r_pending[d_fs_a] ||
                                  r_pending[d_ft_a] || r_pending[d_fd_a]);
  assign w_hazard   = w_load_use || w_fp_haz;

  // Priority chain: downstream stall, taken jump, flush, hazard, FP issue.
  always_comb begin
    w_fd_stall   = 1'b0;
    w_dx_stall   = 1'b0;
    w_dx_bubble  = 1'b0;
    w_fp_issue   = 1'b0;
    w_next_state = r_state;
    w_next_flush = r_flush_cnt;
    if (m_stall) begin
      w_fd_stall = 1'b1;
      w_dx_stall = 1'b1;
    end else if (x_jmp_taken) begin
      w_dx_bubble = 1'b1;
      if (FLUSH_CYC > 1) begin
        w_next_state = S_FLUSH;
        w_next_flush = FL_W'(FLUSH_CYC - 1);
      end else begin
        w_next_state = S_RUN;
      end
    end else if (r_state == S_FLUSH) begin
      w_dx_bubble  = 1'b1;
      w_next_flush = r_flush_cnt - 1'b1;
      if (r_flush_cnt == FL_W'(1)) begin
        w_next_state = S_RUN;
      end
    end else if (w_hazard && d_valid) begin
      w_fd_stall  = 1'b1;
      w_dx_bubble = 1'b1;
    end else if (d_valid && d_is_fp) begin
      w_fp_issue = 1'b1;
    end
  end

  // A write-back and a new issue to the same register: the new issue wins.
  always_comb begin
    w_next_pending = r_pending;
    if (fp_wb_valid) begin
      w_next_pending[fp_wb_a] = 1'b0;
    end
    if (w_fp_issue) begin
      w_next_pending[d_fd_a] = 1'b1;
    end
  end

  // Outputs are forced low asynchronously while reset is held.
  assign fd_stall  = rst && w_fd_stall;
  assign dx_stall  = rst && w_dx_stall;
  assign dx_bubble = rst && w_dx_bubble;
  assign fp_issue  = rst && w_fp_issue;
  assign fp_busy   = w_fp_busy;
  assign stall_cnt = r_stall_cnt;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= '0;
      r_fp_cnt    <= '0;
      r_pending   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush;
      r_pending   <= w_next_pending;
      if (w_fp_issue) begin
        r_fp_cnt <= FC_W'(FP_LAT);
      end else if (w_fp_busy) begin
        r_fp_cnt <= r_fp_cnt - 1'b1;
      end
      if (w_fd_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dx_hazard_ctrl.sv
// Directed bench for dx_hazard_ctrl with a two-cycle jump flush and a
// narrow stall counter so saturation is reachable quickly.
module tb_dx_hazard_ctrl;

  localparam int REG_AW    = 5;
  localparam int FP_LAT    = 4;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 10;

  logic              clk;
  logic              rst;
  logic              d_valid;
  logic [REG_AW-1:0] d_rs_a, d_rt_a;
  logic              d_uses_rs, d_uses_rt;
  logic              d_is_fp;
  logic [REG_AW-1:0] d_fs_a, d_ft_a, d_fd_a;
  logic              x_is_load;
  logic [REG_AW-1:0] x_rd_a;
  logic              x_jmp_taken;
  logic              m_stall;
  logic              fp_wb_valid;
  logic [REG_AW-1:0] fp_wb_a;
  logic              fd_stall, dx_stall, dx_bubble, fp_issue, fp_busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic              dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_sc = 0;

  dx_hazard_ctrl #(
    .REG_AW(REG_AW), .FP_LAT(FP_LAT), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid),
    .d_rs_a(d_rs_a), .d_rt_a(d_rt_a), .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
    .d_is_fp(d_is_fp), .d_fs_a(d_fs_a), .d_ft_a(d_ft_a), .d_fd_a(d_fd_a),
    .x_is_load(x_is_load), .x_rd_a(x_rd_a), .x_jmp_taken(x_jmp_taken),
    .m_stall(m_stall), .fp_wb_valid(fp_wb_valid), .fp_wb_a(fp_wb_a),
    .fd_stall(fd_stall), .dx_stall(dx_stall), .dx_bubble(dx_bubble),
    .fp_issue(fp_issue), .fp_busy(fp_busy), .stall_cnt(stall_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_rs_a = 0; d_rt_a = 0; d_uses_rs = 0; d_uses_rt = 0;
    d_is_fp = 0; d_fs_a = 0; d_ft_a = 0; d_fd_a = 0;
    x_is_load = 0; x_rd_a = 0; x_jmp_taken = 0; m_stall = 0;
    fp_wb_valid = 0; fp_wb_a = 0;
  endtask

  task automatic load_use(input logic [REG_AW-1:0] r);
    d_valid = 1; d_uses_rs = 1; d_rs_a = r; x_is_load = 1; x_rd_a = r;
  endtask

  task automatic fp_op(input logic [REG_AW-1:0] fs, input logic [REG_AW-1:0] ft,
                       input logic [REG_AW-1:0] fd);
    d_valid = 1; d_is_fp = 1; d_fs_a = fs; d_ft_a = ft; d_fd_a = fd;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settles inputs then checks the four controls; an expected stall adds one
  // to the stall count model for the coming edge.
  task automatic chk_ctl(input string tag, input logic fd, input logic dx,
                         input logic bub, input logic iss);
    #1;
    chk({tag, ".fd_stall"},  32'(fd_stall),  32'(fd));
    chk({tag, ".dx_stall"},  32'(dx_stall),  32'(dx));
    chk({tag, ".dx_bubble"}, 32'(dx_bubble), 32'(bub));
    chk({tag, ".fp_issue"},  32'(fp_issue),  32'(iss));
    if (fd) exp_sc++;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    // Outputs must stay low under reset even with every request active.
    m_stall = 1; x_jmp_taken = 1; load_use(5'd3); fp_op(1, 2, 3);
    chk_ctl("rst_held", 0, 0, 0, 0);
    chk("rst_held.fp_busy", 32'(fp_busy), 0);
    chk("rst_held.stall_cnt", 32'(stall_cnt), 0);
    tick(); tick();
    idle();
    rst = 1'b1;

    chk_ctl("idle", 0, 0, 0, 0);
    tick();

    // Load-use hazards
    load_use(5'd3);
    chk_ctl("lu_rs", 1, 0, 1, 0);
    tick();
    chk("lu_rs.stall_cnt", 32'(stall_cnt), 32'(exp_sc));
    x_is_load = 0;
    chk_ctl("lu_gone", 0, 0, 0, 0);
    tick();
    x_is_load = 1; x_rd_a = 0; d_rs_a = 0;
    chk_ctl("lu_r0", 0, 0, 0, 0);
    tick();
    x_rd_a = 7; d_rt_a = 7; d_uses_rt = 0; d_rs_a = 1;
    chk_ctl("lu_rt_unused", 0, 0, 0, 0);
    d_uses_rt = 1;
    chk_ctl("lu_rt", 1, 0, 1, 0);
    tick();
    d_valid = 0;
    chk_ctl("lu_novalid", 0, 0, 0, 0);
    tick();

    // Back-to-back FP ops: second one waits out the unit occupancy
    idle();
    fp_op(1, 2, 5);
    chk_ctl("fp_t0", 0, 0, 0, 1);
    tick();
    fp_op(6, 7, 8);
    for (int i = 1; i <= FP_LAT; i++) begin
      chk_ctl("fp_busy_stall", 1, 0, 1, 0);
      chk("fp_busy_stall.fp_busy", 32'(fp_busy), 1);
      tick();
    end
    chk("fp_t5.fp_busy", 32'(fp_busy), 0);
    chk_ctl("fp_t5", 0, 0, 0, 1);
    tick();
    chk("fp_t5.stall_cnt", 32'(stall_cnt), 32'(exp_sc));

    // Downstream stall over a load-use; FP occupancy keeps draining
    idle();
    m_stall = 1; load_use(5'd4);
    chk_ctl("mstall", 1, 1, 0, 0);
    chk("mstall.fp_busy", 32'(fp_busy), 1);
    tick();
    chk_ctl("mstall2", 1, 1, 0, 0);
    tick();
    idle();
    chk_ctl("mstall_off", 0, 0, 0, 0);
    tick(); tick();
    chk("mstall_drain.fp_busy", 32'(fp_busy), 0);

    // Pending-write dependency on f2
    fp_op(3, 4, 2);
    chk_ctl("fp_issue_f2", 0, 0, 0, 1);
    tick();
    fp_op(2, 9, 10);
    for (int i = 0; i < FP_LAT; i++) begin
      chk_ctl("dep_busy", 1, 0, 1, 0);
      tick();
    end
    chk("dep_pending.fp_busy", 32'(fp_busy), 0);
    chk_ctl("dep_pending", 1, 0, 1, 0);
    tick();
    fp_wb_valid = 1; fp_wb_a = 2;
    chk_ctl("dep_wb_cycle", 1, 0, 1, 0);
    tick();
    fp_wb_valid = 0;
    chk_ctl("dep_issue", 0, 0, 0, 1);
    tick();
    idle();
    for (int i = 0; i < FP_LAT; i++) tick();
    fp_op(11, 12, 8);
    chk_ctl("pend_fd", 1, 0, 1, 0);
    tick();
    fp_op(11, 5, 12);
    chk_ctl("pend_ft", 1, 0, 1, 0);
    tick();
    d_is_fp = 0; d_fs_a = 5;
    chk_ctl("nonfp_ignores", 0, 0, 0, 0);
    tick();
    // Issue and write-back to f14 in the same cycle: f14 stays pending
    fp_op(1, 1, 14); fp_wb_valid = 1; fp_wb_a = 14;
    chk_ctl("set_wins_issue", 0, 0, 0, 1);
    tick();
    idle();
    for (int i = 0; i < FP_LAT; i++) tick();
    fp_op(14, 1, 15);
    chk_ctl("set_wins", 1, 0, 1, 0);
    tick();
    chk("pend.stall_cnt", 32'(stall_cnt), 32'(exp_sc));

    // Taken jump over a pending hazard: two bubbles, no stall counted
    idle();
    load_use(5'd3); x_jmp_taken = 1;
    chk_ctl("jmp", 0, 0, 1, 0);
    tick();
    x_jmp_taken = 0;
    chk("flush.state", 32'(dbg_state), 1);
    chk_ctl("flush", 0, 0, 1, 0);
    tick();
    chk("flush.stall_cnt", 32'(stall_cnt), 32'(exp_sc));
    chk("flush_done.state", 32'(dbg_state), 0);
    chk_ctl("post_flush_lu", 1, 0, 1, 0);
    tick();

    // Downstream stall freezes the flush sequence
    idle();
    x_jmp_taken = 1;
    chk_ctl("jmp2", 0, 0, 1, 0);
    tick();
    x_jmp_taken = 0; m_stall = 1;
    chk_ctl("flush_mstall", 1, 1, 0, 0);
    tick();
    m_stall = 0;
    chk("flush_resume.state", 32'(dbg_state), 1);
    chk_ctl("flush_resume", 0, 0, 1, 0);
    tick();
    chk_ctl("flush_end", 0, 0, 0, 0);
    tick();
    chk("flush_end.stall_cnt", 32'(stall_cnt), 32'(exp_sc));

    // Reset asserted mid-flush with the FP unit busy
    fp_op(21, 22, 20);
    chk_ctl("pre_rst_issue", 0, 0, 0, 1);
    tick();
    idle();
    x_jmp_taken = 1;
    chk_ctl("pre_rst_jmp", 0, 0, 1, 0);
    tick();
    x_jmp_taken = 0;
    #1;
    chk("pre_rst.state", 32'(dbg_state), 1);
    chk("pre_rst.fp_busy", 32'(fp_busy), 1);
    rst = 1'b0;
    m_stall = 1; load_use(5'd6);
    chk_ctl("mid_rst", 0, 0, 0, 0);
    chk("mid_rst.fp_busy", 32'(fp_busy), 0);
    chk("mid_rst.stall_cnt", 32'(stall_cnt), 0);
    chk("mid_rst.state", 32'(dbg_state), 0);
    exp_sc = 0;
    tick();
    idle();
    rst = 1'b1;
    fp_wb_valid = 1; fp_wb_a = 20;
    fp_op(14, 1, 20);
    chk_ctl("post_rst_issue", 0, 0, 0, 1);
    tick();
    idle();
    chk("post_rst.fp_busy", 32'(fp_busy), 1);

    // Stall counter saturation
    m_stall = 1;
    for (int i = 0; i < (1 << CNT_W) - 1; i++) tick();
    chk("sat_reach.stall_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold.stall_cnt", 32'(stall_cnt), 32'((1 << CNT_W) - 1));
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
